mem_stage_wb: RTL
=================

// Module: mem_stage_wb
// PURPOSE
//  MEM pipeline stage plus MEM/WB pipeline register of the MIPS-Lite CPU. Sits directly
//  downstream of the EX/MEM register and consumes its WB/MEM/ALU/RD2/WN outputs.
//  Performs loads and stores over a variable-latency req/ack data-memory port, and stalls
//  the front of the pipe while an access is outstanding. Checks word alignment and bounds
//  every access with a timeout, then registers the results for the WB stage.
// PARAMETERS
//  TIMEOUT   16  max cycles spent waiting for dmem_ack before the access is abandoned (>=1)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  WB_in        in   2   from EX/MEM: [1]=RegWrite, [0]=MemtoReg
//  MEM_in       in   2   from EX/MEM: [1]=MemRead, [0]=MemWrite (both set = treated as read)
//  ALU_in       in   32  from EX/MEM: ALU result / byte address
//  RD2_in       in   32  from EX/MEM: store data
//  WN_in        in   5   from EX/MEM: destination register
//  dmem_req     out  1   data-memory request (level; held until ack or abandon)
//  dmem_we      out  1   1=write, 0=read; valid while dmem_req=1
//  dmem_addr    out  32  =ALU_in while dmem_req=1, else 0
//  dmem_wdata   out  32  =RD2_in while dmem_req=1 and dmem_we=1, else 0
//  dmem_ack     in   1   access complete; dmem_rdata valid in the same cycle for reads
//  dmem_rdata   in   32  read data
//  stall_o      out  1   1 = hold PC/IF-ID/ID-EX/EX-MEM (drives their en_reg low)
//  WB_out       out  2   MEM/WB: control for the WB stage
//  RD_out       out  32  MEM/WB: load data (0 for non-loads)
//  ALU_out      out  32  MEM/WB: ALU result passthrough
//  WN_out       out  5   MEM/WB: destination register
//  align_err    out  1   registered 1-cycle pulse: misaligned access suppressed
//  bus_err      out  1   registered 1-cycle pulse: access abandoned on timeout
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0; WB_out=0, RD_out=0, ALU_out=0, WN_out=0,
//   align_err=0, bus_err=0. dmem_req and stall_o are 0 in the cycle following reset.
//  memop = MEM_in[1] | MEM_in[0]; misal = memop & (ALU_in[1:0] != 2'b00).
//  FSM states IDLE and WAIT:
//   IDLE: if memop & ~misal: assert dmem_req, with dmem_we = MEM_in[0] & ~MEM_in[1].
//         If dmem_ack is high in the same cycle: the access completes (zero-wait) and the
//         state stays IDLE. Otherwise go to WAIT with counter=1.
//   WAIT: keep dmem_req asserted; address/data are stable because EX/MEM is stalled.
//         On dmem_ack: complete and go to IDLE.
//         Else if counter==TIMEOUT: abandon, bus_err<=1, go to IDLE. Else counter++.
//  stall_o = (memop & ~misal & ~dmem_ack & state==IDLE) | (state==WAIT & ~dmem_ack
//   & counter!=TIMEOUT). This is combinational from dmem_ack, by design.
//  MEM/WB register update, every posedge when not in reset:
//   stall_o=1 -> insert bubble: WB_out<=0. RD_out, ALU_out and WN_out hold.
//   Completion or no memop -> WB_out<=WB_in, ALU_out<=ALU_in, WN_out<=WN_in, and
//     RD_out<=dmem_rdata for a read, else 0.
//   misal -> no request is issued; WB_out<={1'b0,WB_in[0]}, i.e. the register write is
//     killed. ALU_out and WN_out load normally, RD_out<=0, align_err<=1. Stall is 0.
//   bus_err abandon -> as misal, but bus_err<=1 instead of align_err.
//  align_err and bus_err are 0 in every cycle except those described above.
//  A store never writes back: WB_in from the decoder already has RegWrite=0. This block
//   does not alter WB_in for a store.
//  Reset during WAIT: the request drops next cycle, the FSM goes to IDLE and the MEM/WB
//   register clears. A late dmem_ack after reset is ignored.
//  ack while IDLE with no memop: ignored.
//  Latency: a non-memory instruction reaches MEM/WB 1 cycle after it appears at the inputs.
//   A memory instruction takes 1 + N cycles, where N = ack wait cycles.
// TESTING
//  1 ALU op: WB_in=2'b10, ALU_in=32'h1234, WN_in=5 -> next cycle WB_out=2'b10,
//    ALU_out=32'h1234, WN_out=5, RD_out=0; dmem_req=0 and stall_o=0 throughout.
//  2 Zero-wait load: MEM_in=2'b10, ALU_in=32'h40, ack in the same cycle with rdata=32'hCAFE
//    -> stall_o=0; next cycle RD_out=32'hCAFE, WB_out=WB_in.
//  3 3-wait store: MEM_in=2'b01, ALU_in=32'h80, RD2_in=32'h55, ack on the 4th cycle
//    -> dmem_we=1 with wdata=32'h55 for 4 cycles; stall_o=1 for 3 cycles; 3 bubbles
//    (WB_out=0); then the store's WB_out loads.
//  4 Misaligned load: ALU_in=32'h42, WB_in=2'b11 -> dmem_req=0, stall_o=0; next cycle
//    WB_out=2'b01 and align_err=1 for exactly 1 cycle.
//  5 Timeout: load with no ack and TIMEOUT=4 -> dmem_req high for 5 cycles, stall_o high
//    for 4 cycles; bus_err pulses; WB_out[1]=0; the next instruction proceeds.
//  6 rst asserted in WAIT, then ack arrives 1 cycle later -> all outputs 0 and the ack
//    causes no MEM/WB update.

Source files
------------

// File: rtl/mem_stage_wb.sv
// MEM stage and MEM/WB pipeline register for the MIPS-Lite CPU. It runs loads and stores
// over a req/ack data-memory port, stalls the front of the pipe while an access is pending, and bounds each access with a timeout.
module mem_stage_wb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  MEM_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] RD2_in,
    input  logic [4:0]  WN_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_o,
    output logic [1:0]  WB_out,
    output logic [31:0] RD_out,
    output logic [31:0] ALU_out,
    output logic [4:0]  WN_out,
    output logic        align_err,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     wb_q;
    logic [31:0]    rd_q, alu_q;
    logic [4:0]     wn_q;
    logic           align_q, bus_q;

    logic memop, misal, go, is_read, is_write;
    logic req, stall, complete, abandon;

    assign memop    = MEM_in[1] | MEM_in[0];
    // Alignment is only evaluated when an access would start; in WAIT the inputs are frozen and aligned.
    assign misal    = memop & (ALU_in[1:0] != 2'b00) & (state_q == IDLE);
    assign go       = memop & (ALU_in[1:0] == 2'b00) & (state_q == IDLE);
    assign is_read  = MEM_in[1];
    assign is_write = MEM_in[0] & ~MEM_in[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        abandon  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == TO_C) begin
                    abandon = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            wn_q    <= '0;
            align_q <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            align_q <= 1'b0;
            bus_q   <= 1'b0;
            if (stall) begin
                wb_q <= '0;
            end else if (misal || abandon) begin
                // Failed access: instruction retires with its register write killed.
                wb_q    <= {1'b0, WB_in[0]};
                alu_q   <= ALU_in;
                wn_q    <= WN_in;
                rd_q    <= '0;
                align_q <= misal;
                bus_q   <= abandon;
            end else begin
                wb_q  <= WB_in;
                alu_q <= ALU_in;
                wn_q  <= WN_in;
                rd_q  <= (complete && is_read) ? dmem_rdata : 32'd0;
            end
        end
    end

    assign dmem_req   = req;
    assign dmem_we    = req & is_write;
    assign dmem_addr  = req ? ALU_in : 32'd0;
    assign dmem_wdata = (req && is_write) ? RD2_in : 32'd0;
    assign stall_o    = stall;
    assign WB_out     = wb_q;
    assign RD_out     = rd_q;
    assign ALU_out    = alu_q;
    assign WN_out     = wn_q;
    assign align_err  = align_q;
    assign bus_err    = bus_q;

endmodule
